// File: rtl/instr_encoder_loader.sv
// Hardware assembler/loader: packs instruction field bundles into 16-bit words and
// writes them to consecutive instruction-RAM addresses while holding the CPU.
module instr_encoder_loader #(
    parameter int unsigned         ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_ra,
    input  logic [3:0]        in_rb,
    input  logic [7:0]        in_imm,
    input  logic              in_bsel,
    input  logic              in_bflag,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [3:0] ADD_OP = 4'h1;
    localparam logic [3:0] MV_OP  = 4'h2;
    localparam logic [3:0] LDI_OP = 4'h3;
    localparam logic [3:0] LDR_OP = 4'h4;
    localparam logic [3:0] ST_OP  = 4'h5;
    localparam logic [3:0] BRI_OP = 4'h6;
    localparam logic [3:0] BRR_OP = 4'h7;

    typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StErr} stateT;

    stateT             state;
    logic [ADDR_W-1:0] addr;
    logic              lastReg;
    logic [15:0]       encWord;
    logic              opLegal;

    always_comb begin
        encWord = 16'h0000;
        opLegal = 1'b1;
        case (in_op)
            ADD_OP, MV_OP, LDR_OP, ST_OP: encWord = {in_op, in_ra, in_rb, 4'h0};
            LDI_OP:                       encWord = {in_op, in_ra, in_imm};
            BRI_OP:                       encWord = {in_op, 2'b00, in_bsel, in_bflag, in_imm};
            BRR_OP:                       encWord = {in_op, 2'b00, in_bsel, in_bflag, in_rb, 4'h0};
            default:                      opLegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            addr       <= BASE_ADDR;
            lastReg    <= 1'b0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            count      <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state    <= StAccept;
                        addr     <= BASE_ADDR;
                        count    <= '0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                StAccept: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (opLegal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr;
                            imem_wdata <= encWord;
                            lastReg    <= in_last;
                            state      <= StWrite;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= StErr;
                        end
                    end
                end
                StWrite: begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                    // in_last wins over overflow on the final RAM location
                    if (lastReg) begin
                        state    <= StDone;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (addr == '1) begin
                        state    <= StErr;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        state    <= StAccept;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed plus randomized bench for instr_encoder_loader; an 8-bit-address instance
// covers the main flows and a 2-bit-address instance covers memory overflow.
module tb_instr_encoder_loader;

    localparam logic [3:0] ADD_OP = 4'h1;
    localparam logic [3:0] MV_OP  = 4'h2;
    localparam logic [3:0] LDI_OP = 4'h3;
    localparam logic [3:0] LDR_OP = 4'h4;
    localparam logic [3:0] ST_OP  = 4'h5;
    localparam logic [3:0] BRI_OP = 4'h6;
    localparam logic [3:0] BRR_OP = 4'h7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, startA, startB, in_valid;
    logic [3:0] in_op, in_ra, in_rb;
    logic [7:0] in_imm;
    logic       in_bsel, in_bflag, in_last;

    logic        readyA, weA, holdA, doneA, errA;
    logic [7:0]  addrA;
    logic [15:0] wdataA;
    logic [1:0]  codeA;
    logic [8:0]  countA;

    logic        readyB, weB, holdB, doneB, errB;
    logic [1:0]  addrB;
    logic [15:0] wdataB;
    logic [1:0]  codeB;
    logic [2:0]  countB;

    instr_encoder_loader #(.ADDR_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .in_valid(in_valid), .in_ready(readyA),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_bsel(in_bsel),
        .in_bflag(in_bflag), .in_last(in_last), .imem_we(weA), .imem_addr(addrA),
        .imem_wdata(wdataA), .cpu_hold(holdA), .done(doneA), .err(errA),
        .err_code(codeA), .count(countA)
    );

    instr_encoder_loader #(.ADDR_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .in_valid(in_valid), .in_ready(readyB),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_bsel(in_bsel),
        .in_bflag(in_bflag), .in_last(in_last), .imem_we(weB), .imem_addr(addrB),
        .imem_wdata(wdataB), .cpu_hold(holdB), .done(doneB), .err(errB),
        .err_code(codeB), .count(countB)
    );

    int nCmp = 0;
    int nErr = 0;
    bit useB = 1'b0;
    int expAddr = 0;
    int expCount = 0;

    logic        sReady, sWe, sHold, sDone, sErr;
    logic [1:0]  sCode;
    logic [15:0] sWdata;
    logic [31:0] sAddr, sCount;

    always_comb begin
        sReady = useB ? readyB : readyA;
        sWe    = useB ? weB    : weA;
        sHold  = useB ? holdB  : holdA;
        sDone  = useB ? doneB  : doneA;
        sErr   = useB ? errB   : errA;
        sCode  = useB ? codeB  : codeA;
        sWdata = useB ? wdataB : wdataA;
        sAddr  = useB ? 32'(addrB)  : 32'(addrA);
        sCount = useB ? 32'(countB) : 32'(countA);
    end

    function automatic bit refLegal(input logic [3:0] op);
        return op inside {ADD_OP, MV_OP, LDI_OP, LDR_OP, ST_OP, BRI_OP, BRR_OP};
    endfunction

    function automatic logic [15:0] refEnc(input logic [3:0] op, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [7:0] imm,
                                           input logic bsel, input logic bflag);
        int w;
        int flags;
        w = int'(op) * 4096;
        flags = int'(bsel) * 2 + int'(bflag);
        if (op inside {ADD_OP, MV_OP, LDR_OP, ST_OP}) w += int'(ra) * 256 + int'(rb) * 16;
        else if (op == LDI_OP) w += int'(ra) * 256 + int'(imm);
        else if (op == BRI_OP) w += flags * 256 + int'(imm);
        else if (op == BRR_OP) w += flags * 256 + int'(rb) * 16;
        return 16'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart;
        if (useB) startB = 1'b1;
        else startA = 1'b1;
        tick();
        startA = 1'b0;
        startB = 1'b0;
        expAddr = 0;
        expCount = 0;
        chk("start_ready", 32'(sReady), 1);
        chk("start_hold", 32'(sHold), 1);
        chk("start_err", 32'(sErr), 0);
        chk("start_code", 32'(sCode), 0);
        chk("start_count", sCount, 0);
    endtask

    // Offers one bundle, waits (bounded) for the handshake, then checks the outcome.
    task automatic send(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [7:0] imm, input logic bsel, input logic bflag,
                        input logic last, output bit acc);
        int limit;
        limit = useB ? 4 : 256;
        in_op = op; in_ra = ra; in_rb = rb; in_imm = imm;
        in_bsel = bsel; in_bflag = bflag; in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sReady) begin
                acc = 1'b1;
                tick();
                break;
            end
            chk("no_write_while_waiting", 32'(sWe), 0);
            tick();
        end
        in_valid = 1'b0;
        if (!acc) return;
        if (refLegal(op)) begin
            chk("write_we", 32'(sWe), 1);
            chk("write_addr", sAddr, 32'(expAddr));
            chk("write_wdata", 32'(sWdata), 32'(refEnc(op, ra, rb, imm, bsel, bflag)));
            chk("write_ready_low", 32'(sReady), 0);
            tick();
            expCount++;
            chk("after_write_we", 32'(sWe), 0);
            chk("after_write_count", sCount, 32'(expCount));
            if (last) begin
                chk("done_pulse", 32'(sDone), 1);
                chk("done_hold", 32'(sHold), 0);
                tick();
                chk("done_single", 32'(sDone), 0);
                chk("done_count_held", sCount, 32'(expCount));
            end else if (expAddr == limit - 1) begin
                chk("ovf_err", 32'(sErr), 1);
                chk("ovf_code", 32'(sCode), 2);
                chk("ovf_hold", 32'(sHold), 1);
                chk("ovf_ready", 32'(sReady), 0);
            end else begin
                chk("next_ready", 32'(sReady), 1);
            end
            expAddr++;
        end else begin
            chk("illegal_we", 32'(sWe), 0);
            chk("illegal_err", 32'(sErr), 1);
            chk("illegal_code", 32'(sCode), 1);
            chk("illegal_hold", 32'(sHold), 1);
            chk("illegal_ready", 32'(sReady), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [3:0] legalOps [7];
        legalOps = '{ADD_OP, MV_OP, LDI_OP, LDR_OP, ST_OP, BRI_OP, BRR_OP};

        rst_n = 1'b0; startA = 1'b0; startB = 1'b0; in_valid = 1'b0;
        in_op = '0; in_ra = '0; in_rb = '0; in_imm = '0;
        in_bsel = 1'b0; in_bflag = 1'b0; in_last = 1'b0;
        #12;
        chk("rst_ready", 32'(readyA), 0);
        chk("rst_we", 32'(weA), 0);
        chk("rst_hold", 32'(holdA), 0);
        chk("rst_done", 32'(doneA), 0);
        chk("rst_err", 32'(errA), 0);
        chk("rst_count", 32'(countA), 0);
        chk("rst_addr", 32'(addrA), 0);
        chk("rstB_hold", 32'(holdB), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(readyA), 0);

        // Single LDI
        pulseStart();
        send(LDI_OP, 4'h3, 4'h0, 8'h5A, 1'b0, 1'b0, 1'b1, acc);
        chk("t1_acc", 32'(acc), 1);

        // Three back-to-back bundles
        pulseStart();
        send(ADD_OP, 4'h1, 4'h2, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        chk("t2_acc0", 32'(acc), 1);
        send(BRI_OP, 4'h0, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0, acc);
        chk("t2_acc1", 32'(acc), 1);
        send(BRR_OP, 4'h0, 4'h7, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        chk("t2_acc2", 32'(acc), 1);

        // Illegal opcode as second bundle, then recovery
        pulseStart();
        send(MV_OP, 4'h4, 4'h5, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        send(4'hF, 4'h1, 4'h1, 8'h01, 1'b0, 1'b0, 1'b0, acc);
        chk("t3_acc", 32'(acc), 1);
        tick();
        chk("t3_sticky_err", 32'(errA), 1);
        chk("t3_count", 32'(countA), 1);
        pulseStart();
        send(ST_OP, 4'h2, 4'h9, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Overflow on the 2-bit-address instance
        useB = 1'b1;
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            send(legalOps[k], 4'(k), 4'(k + 3), 8'(k * 17), 1'b0, 1'b1, 1'b0, acc);
            chk("t4_acc", 32'(acc), 1);
        end
        chk("t4_count", sCount, 4);
        send(ADD_OP, 4'h1, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_fifth_rejected", 32'(acc), 0);
        chk("t4_code_kept", 32'(sCode), 2);
        useB = 1'b0;

        // Reset during the second write, then start ignored in ACCEPT
        pulseStart();
        send(ADD_OP, 4'h1, 4'h2, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        in_op = LDI_OP; in_ra = 4'h6; in_imm = 8'hC3; in_last = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_in_write", 32'(weA), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(weA), 0);
        chk("t5_rst_hold", 32'(holdA), 0);
        chk("t5_rst_ready", 32'(readyA), 0);
        chk("t5_rst_count", 32'(countA), 0);
        chk("t5_rst_addr", 32'(addrA), 0);
        chk("t5_rst_wdata", 32'(wdataA), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5_idle_hold", 32'(holdA), 0);
        pulseStart();
        send(MV_OP, 4'h7, 4'h8, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        startA = 1'b1;
        tick();
        startA = 1'b0;
        chk("t5_start_ign_count", 32'(countA), 1);
        chk("t5_start_ign_ready", 32'(readyA), 1);
        send(LDR_OP, 4'hA, 4'hB, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Idle in ACCEPT
        pulseStart();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_we", 32'(weA), 0);
            chk("t6_hold", 32'(holdA), 1);
            chk("t6_ready", 32'(readyA), 1);
        end
        send(ST_OP, 4'h3, 4'h4, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            int len;
            int badAt;
            pulseStart();
            len = int'($urandom_range(1, 6));
            badAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int k = 0; k < len; k++) begin
                logic [3:0] op;
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("rnd_gap_we", 32'(weA), 0);
                end
                if (k == badAt) begin
                    int r;
                    r = int'($urandom_range(8, 16));
                    op = (r == 16) ? 4'h0 : 4'(r);
                end else begin
                    op = legalOps[$urandom_range(0, 6)];
                end
                send(op, 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom),
                     1'($urandom), 1'(k == len - 1), acc);
                chk("rnd_acc", 32'(acc), 1);
                if (k == badAt) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
